gcd_sub_ctrl: RTL and testbench

Sequential controller that computes the greatest common divisor of two 64-bit unsigned operands by repeated subtraction. It time-shares a single instance of the team's 64-bit ripple-carry subtractor: difference = in1 + ~in2 + 1, and carry-out = 1 means no borrow, i.e. in1 ≥ in2. The block owns the operand registers, the FSM, the iteration counter and a timeout guard. It sits between a requester issuing start/operands and that subtractor datapath.

---
 rtl/gcd_sub_ctrl.sv | 146 ++++++++++++++
 tb/tb_gcd_sub_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_sub_ctrl.sv
// GCD controller by repeated subtraction over a shared 64-bit
// ripple-carry subtractor, with iteration count and timeout guard.
module gcd_sub_rca #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  output logic [W-1:0] diff,
  output logic         cout
);

  logic [W-1:0] nb;
  logic         c;

  assign nb = ~in2;

  // in1 + ~in2 + 1, one full adder per bit
  always_comb begin
    diff = '0;
    c    = 1'b1;
    for (int i = 0; i < W; i++) begin
      diff[i] = in1[i] ^ nb[i] ^ c;
      c = (in1[i] & nb[i]) | (in1[i] & c) | (nb[i] & c);
    end
    cout = c;
  end

endmodule

module gcd_sub_ctrl #(
  parameter logic [31:0] MAX_CYCLES = 32'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [63:0] result,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [63:0] a_q, a_n;
  logic [63:0] b_q, b_n;
  logic [31:0] cnt_q, cnt_n;
  logic        err_q, err_n;
  logic [63:0] res_q, res_n;

  logic [63:0] diff;
  logic        no_borrow;
  logic        diff_zero;

  gcd_sub_rca #(.W(64)) u_sub (
    .in1  (a_q),
    .in2  (b_q),
    .diff (diff),
    .cout (no_borrow)
  );

  assign diff_zero = (diff == 64'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_n;
      a_q     <= a_n;
      b_q     <= b_n;
      cnt_q   <= cnt_n;
      err_q   <= err_n;
      res_q   <= res_n;
    end
  end

  always_comb begin
    state_n = state_q;
    a_n     = a_q;
    b_n     = b_q;
    cnt_n   = cnt_q;
    err_n   = err_q;
    res_n   = res_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_n   = a;
          b_n   = b;
          cnt_n = '0;
          err_n = 1'b0;
          res_n = '0;
          if (a == 64'd0 || b == 64'd0) begin
            res_n   = a | b;
            state_n = DONE;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        // timeout outranks convergence on the same cycle
        if (cnt_q == MAX_CYCLES) begin
          err_n   = 1'b1;
          res_n   = '0;
          state_n = DONE;
        end else if (no_borrow && diff_zero) begin
          res_n   = a_q;
          cnt_n   = cnt_q + 32'd1;
          state_n = DONE;
        end else if (no_borrow) begin
          a_n   = diff;
          cnt_n = cnt_q + 32'd1;
        end else begin
          a_n   = b_q;
          b_n   = a_q;
          cnt_n = cnt_q + 32'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign err    = err_q;
  assign result = res_q;
  assign cycles = cnt_q;

endmodule

// File: tb/tb_gcd_sub_ctrl.sv
// Directed bench for gcd_sub_ctrl: latency, result, cycle count,
// timeout, reset abort, ignored start and output hold.
module tb_gcd_sub_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [63:0] a;
  logic [63:0] b;
  logic        busy;
  logic        done;
  logic        err;
  logic [63:0] result;
  logic [31:0] cycles;

  int n_chk;
  int n_fail;

  gcd_sub_ctrl #(.MAX_CYCLES(32'd16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result),
    .cycles (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // lat = edges after the start edge before done is seen
  task automatic run_op(input string tag,
                        input logic [63:0] av,
                        input logic [63:0] bv,
                        input logic [63:0] er,
                        input logic [31:0] ec,
                        input logic ee,
                        input int elat);
    int lat;
    @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 300) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 64'(lat), 64'(elat));
    chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    chk({tag, "_res"}, result, er);
    chk({tag, "_cyc"}, {32'd0, cycles}, {32'd0, ec});
    chk({tag, "_err"}, {63'd0, err}, {63'd0, ee});
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    logic [63:0] hold_r;
    logic [31:0] hold_c;
    int seen;
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_err", {63'd0, err}, 64'd0);
    chk("rst_res", result, 64'd0);
    chk("rst_cyc", {32'd0, cycles}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic", 64'd12, 64'd8, 64'd4, 32'd4, 1'b0, 4);

    // reset during the third RUN cycle
    @(negedge clk);
    a = 64'd1;
    b = 64'd1000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("mr_run", {63'd0, busy}, 64'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_busy", {63'd0, busy}, 64'd0);
    chk("mr_done", {63'd0, done}, 64'd0);
    chk("mr_res", result, 64'd0);
    chk("mr_cyc", {32'd0, cycles}, 64'd0);
    chk("mr_err", {63'd0, err}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("mr_quiet", 64'(seen), 64'd0);

    run_op("eq", 64'd7, 64'd7, 64'd7, 32'd1, 1'b0, 1);
    run_op("z09", 64'd0, 64'd9, 64'd9, 32'd0, 1'b0, 0);
    run_op("z00", 64'd0, 64'd0, 64'd0, 32'd0, 1'b0, 0);
    run_op("swap", 64'd1, 64'd5, 64'd1, 32'd6, 1'b0, 6);
    run_op("wide", 64'hFFFF_FFFF_FFFF_FFFE,
           64'h7FFF_FFFF_FFFF_FFFF,
           64'h7FFF_FFFF_FFFF_FFFF, 32'd2, 1'b0, 2);
    run_op("tmo", 64'd1, 64'd100, 64'd0, 32'd16, 1'b1, 17);
    run_op("after", 64'd6, 64'd4, 64'd2, 32'd4, 1'b0, 4);

    // start pulsed mid-RUN must be dropped
    @(negedge clk);
    a = 64'd12;
    b = 64'd8;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 64'd3;
    b = 64'd9;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    seen = 0;
    while (!done && seen < 300) begin
      @(posedge clk);
      #1;
      seen++;
    end
    chk("ign_lat", 64'(seen), 64'd2);
    chk("ign_res", result, 64'd4);
    chk("ign_cyc", {32'd0, cycles}, 64'd4);

    hold_r = result;
    hold_c = cycles;
    seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (result !== 64'd4 || cycles !== 32'd4 || busy || done)
        seen++;
    end
    chk("hold", 64'(seen), 64'd0);
    chk("hold_res", hold_r, 64'd4);
    chk("hold_cyc", {32'd0, hold_c}, 64'd4);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
